// File: rtl/mem_req_arb.sv
// Round-robin arbiter that hands one DDR transfer descriptor at a time to mem_ctrl and
// holds the grant until mc_done, with a watchdog that aborts a transfer whose completion is lost.
module mem_req_arb #(
  parameter int NUM_CLIENTS = 16,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT     = 4096
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CLIENTS-1:0]             cl_req,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] cl_rd_addr,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] cl_wr_addr,
  output logic [NUM_CLIENTS-1:0]             cl_gnt,
  output logic [NUM_CLIENTS-1:0]             cl_done,
  output logic                               mc_valid,
  input  logic                               mc_ready,
  output logic [ADDR_W-1:0]                  read_addr_ddr,
  output logic [ADDR_W-1:0]                  write_addr_ddr,
  output logic [4:0]                         client_priority,
  input  logic                               mc_done,
  output logic                               busy,
  output logic                               timeout_err
);
  localparam int              WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [4:0]      LAST_ID  = 5'(NUM_CLIENTS - 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARB, ISSUE, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [4:0]             rr_ptr_q, rr_ptr_d;
  logic [4:0]             id_q, id_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   timeout_err_q, timeout_err_d;

  logic [NUM_CLIENTS-1:0] req_rot;
  logic                   win_vld;
  logic [5:0]             win_sum;
  logic [4:0]             win_id;
  logic [NUM_CLIENTS-1:0] id_oh;
  logic                   wd_expire;
  logic                   xfer_end;

  assign wd_expire = (state_q == BUSY) && (wd_q == WD_LIMIT);
  assign xfer_end  = (state_q == BUSY) && (mc_done || wd_expire);

  // Rotate so bit 0 is the client at rr_ptr; the first set bit wins.
  always_comb begin
    req_rot = NUM_CLIENTS'({cl_req, cl_req} >> rr_ptr_q);
    win_vld = 1'b0;
    win_sum = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!win_vld && req_rot[i]) begin
        win_vld = 1'b1;
        win_sum = {1'b0, rr_ptr_q} + 6'(i);
      end
    end
    if (win_sum >= 6'(NUM_CLIENTS)) win_sum = win_sum - 6'(NUM_CLIENTS);
    win_id = 5'(win_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Completion with requests pending goes straight to ARB to keep the 2-cycle turnaround.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|cl_req) state_d = ARB;
      ARB:     state_d = win_vld ? ISSUE : IDLE;
      ISSUE:   if (mc_ready) state_d = BUSY;
      BUSY:    if (xfer_end) state_d = (|cl_req) ? ARB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) id_oh[i] = (5'(i) == id_q);
    mc_valid = (state_q == ISSUE);
    busy     = (state_q == ISSUE) || (state_q == BUSY);
    cl_gnt   = ((state_q == ISSUE) && mc_ready) ? id_oh : '0;
    cl_done  = xfer_end ? id_oh : '0;
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_d     = wr_addr_q;
    wd_d          = ((state_q == BUSY) && !xfer_end) ? wd_q + WD_W'(1) : '0;
    // A completion landing on the expiry cycle wins: no error.
    timeout_err_d = timeout_err_q | (wd_expire & ~mc_done);
    if ((state_q == ARB) && win_vld) begin
      id_d = win_id;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (5'(i) == win_id) begin
          rd_addr_d = cl_rd_addr[i];
          wr_addr_d = cl_wr_addr[i];
        end
      end
    end
    if (xfer_end) rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      id_q          <= '0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign read_addr_ddr   = rd_addr_q;
  assign write_addr_ddr  = wr_addr_q;
  assign client_priority = id_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_mem_req_arb.sv
// Directed bench for mem_req_arb: reset, single transfer, fairness, backpressure,
// watchdog, pointer wrap, mid-transfer reset and completion on the expiry cycle.
`timescale 1ns/1ps
module tb_mem_req_arb;
  localparam int N  = 16;
  localparam int AW = 32;
  localparam int TO = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [N-1:0]           cl_req = '0;
  logic [N-1:0][AW-1:0]   cl_rd_addr, cl_wr_addr;
  logic [N-1:0]           cl_gnt, cl_done;
  logic                   mc_valid, busy, timeout_err;
  logic                   mc_ready = 1'b0;
  logic                   mc_done  = 1'b0;
  logic [AW-1:0]          read_addr_ddr, write_addr_ddr;
  logic [4:0]             client_priority;
  int                     vectors = 0;
  int                     miscompares = 0;

  always #5 clk = ~clk;

  mem_req_arb #(.NUM_CLIENTS(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cl_req(cl_req), .cl_rd_addr(cl_rd_addr), .cl_wr_addr(cl_wr_addr),
    .cl_gnt(cl_gnt), .cl_done(cl_done), .mc_valid(mc_valid), .mc_ready(mc_ready),
    .read_addr_ddr(read_addr_ddr), .write_addr_ddr(write_addr_ddr),
    .client_priority(client_priority), .mc_done(mc_done), .busy(busy), .timeout_err(timeout_err)
  );

  function automatic logic [AW-1:0] rd_of(int i);
    return 32'hA000_0000 + 32'(i) * 32'h100;
  endfunction
  function automatic logic [AW-1:0] wr_of(int i);
    return 32'hB000_0000 + 32'(i) * 32'h100;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    tick(); rst = 1'b1; cl_req = '0; mc_done = 1'b0;
    tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    smp();
    vectors++; if (mc_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mc_valid got=%0b exp=0", mc_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    vectors++; if (cl_gnt !== '0) begin miscompares++; $display("FAIL rst_gnt got=%h exp=0", cl_gnt); end
    vectors++; if (cl_done !== '0) begin miscompares++; $display("FAIL rst_done got=%h exp=0", cl_done); end
    vectors++; if (read_addr_ddr !== '0) begin miscompares++; $display("FAIL rst_rd_addr got=%h exp=0", read_addr_ddr); end
    vectors++; if (write_addr_ddr !== '0) begin miscompares++; $display("FAIL rst_wr_addr got=%h exp=0", write_addr_ddr); end
    vectors++; if (client_priority !== 5'd0) begin miscompares++; $display("FAIL rst_prio got=%0d exp=0", client_priority); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_timeout_err got=%0b exp=0", timeout_err); end
    tick(); rst = 1'b0;
  endtask

  task automatic test_single();
    tick(); mc_ready = 1'b1; cl_rd_addr[3] = 32'h1000; cl_wr_addr[3] = 32'h2000; cl_req = 16'h0008;
    smp();
    vectors++; if (mc_valid !== 1'b0) begin miscompares++; $display("FAIL t1_valid_c0 got=%0b exp=0", mc_valid); end
    tick(); smp();
    vectors++; if (mc_valid !== 1'b0) begin miscompares++; $display("FAIL t1_valid_c1 got=%0b exp=0", mc_valid); end
    tick(); smp();
    vectors++; if (mc_valid !== 1'b1) begin miscompares++; $display("FAIL t1_valid_c2 got=%0b exp=1", mc_valid); end
    vectors++; if (client_priority !== 5'd3) begin miscompares++; $display("FAIL t1_prio got=%0d exp=3", client_priority); end
    vectors++; if (read_addr_ddr !== 32'h1000) begin miscompares++; $display("FAIL t1_rd_addr got=%h exp=1000", read_addr_ddr); end
    vectors++; if (write_addr_ddr !== 32'h2000) begin miscompares++; $display("FAIL t1_wr_addr got=%h exp=2000", write_addr_ddr); end
    vectors++; if (cl_gnt !== 16'h0008) begin miscompares++; $display("FAIL t1_gnt got=%h exp=0008", cl_gnt); end
    tick(); cl_req = '0; smp();
    vectors++; if ({busy, mc_valid, cl_gnt} !== {1'b1, 1'b0, 16'h0}) begin miscompares++; $display("FAIL t1_busy_state got=%b/%b/%h exp=1/0/0000", busy, mc_valid, cl_gnt); end
    tick(); tick(); mc_done = 1'b1; smp();
    vectors++; if (cl_done !== 16'h0008) begin miscompares++; $display("FAIL t1_done got=%h exp=0008", cl_done); end
    tick(); mc_done = 1'b0; smp();
    vectors++; if ({busy, cl_done} !== {1'b0, 16'h0}) begin miscompares++; $display("FAIL t1_idle got=%b/%h exp=0/0000", busy, cl_done); end
    cl_rd_addr[3] = rd_of(3); cl_wr_addr[3] = wr_of(3);
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp;
    int n;
    apply_reset();
    cl_req = '1; mc_ready = 1'b1; smp();
    for (int k = 0; k <= N; k++) begin
      n = 0;
      while (cl_gnt == '0 && n < 8) begin tick(); smp(); n++; end
      exp = N'(1) << (k % N);
      vectors++; if (cl_gnt !== exp) begin miscompares++; $display("FAIL t2_gnt_%0d got=%h exp=%h", k, cl_gnt, exp); end
      if (k == N) break;
      vectors++; if (client_priority !== 5'(k)) begin miscompares++; $display("FAIL t2_prio_%0d got=%0d exp=%0d", k, client_priority, k); end
      for (int j = 0; j < 5; j++) tick();
      mc_done = 1'b1; smp();
      vectors++; if (cl_done !== exp) begin miscompares++; $display("FAIL t2_done_%0d got=%h exp=%h", k, cl_done, exp); end
      tick(); mc_done = 1'b0; smp();
      vectors++; if (mc_valid !== 1'b0) begin miscompares++; $display("FAIL t2_turn1_%0d got=%0b exp=0", k, mc_valid); end
      tick(); smp();
      vectors++; if (mc_valid !== 1'b1) begin miscompares++; $display("FAIL t2_turn2_%0d got=%0b exp=1", k, mc_valid); end
    end
    tick(); cl_req = '0; tick(); mc_done = 1'b1; tick(); mc_done = 1'b0; tick();
  endtask

  task automatic test_backpressure();
    int n;
    tick(); cl_req = 16'h0020; mc_ready = 1'b0; smp();
    n = 0;
    while (!mc_valid && n < 8) begin tick(); smp(); n++; end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin tick(); smp(); end
      vectors++; if (mc_valid !== 1'b1) begin miscompares++; $display("FAIL t3_valid_%0d got=%0b exp=1", i, mc_valid); end
      vectors++; if (read_addr_ddr !== rd_of(5)) begin miscompares++; $display("FAIL t3_rd_%0d got=%h exp=%h", i, read_addr_ddr, rd_of(5)); end
      vectors++; if (write_addr_ddr !== wr_of(5)) begin miscompares++; $display("FAIL t3_wr_%0d got=%h exp=%h", i, write_addr_ddr, wr_of(5)); end
      vectors++; if (client_priority !== 5'd5) begin miscompares++; $display("FAIL t3_prio_%0d got=%0d exp=5", i, client_priority); end
      vectors++; if (cl_gnt !== '0) begin miscompares++; $display("FAIL t3_nognt_%0d got=%h exp=0000", i, cl_gnt); end
      if (i == 0) cl_rd_addr[5] = 32'hDEAD_BEEF;
    end
    tick(); mc_ready = 1'b1; smp();
    vectors++; if (cl_gnt !== 16'h0020) begin miscompares++; $display("FAIL t3_gnt got=%h exp=0020", cl_gnt); end
    tick(); cl_req = '0; cl_rd_addr[5] = rd_of(5); smp();
    vectors++; if ({busy, mc_valid} !== 2'b10) begin miscompares++; $display("FAIL t3_after_gnt got=%b exp=10", {busy, mc_valid}); end
    tick(); mc_done = 1'b1; smp();
    vectors++; if (cl_done !== 16'h0020) begin miscompares++; $display("FAIL t3_done got=%h exp=0020", cl_done); end
    tick(); mc_done = 1'b0;
  endtask

  task automatic test_watchdog();
    int n;
    tick(); cl_req = 16'h0200; smp();
    n = 0;
    while (cl_gnt == '0 && n < 8) begin tick(); smp(); n++; end
    vectors++; if (cl_gnt !== 16'h0200) begin miscompares++; $display("FAIL t4_gnt got=%h exp=0200", cl_gnt); end
    for (int c = 1; c <= TO; c++) begin
      tick(); if (c == 1) cl_req = '0; smp();
      vectors++; if ({busy, cl_done} !== {1'b1, 16'h0}) begin miscompares++; $display("FAIL t4_wait_%0d got=%b/%h exp=1/0000", c, busy, cl_done); end
    end
    tick(); smp();
    vectors++; if (cl_done !== 16'h0200) begin miscompares++; $display("FAIL t4_abort_done got=%h exp=0200", cl_done); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL t4_err_early got=%0b exp=0", timeout_err); end
    tick(); smp();
    vectors++; if ({timeout_err, busy, cl_done} !== {1'b1, 1'b0, 16'h0}) begin miscompares++; $display("FAIL t4_after got=%b/%b/%h exp=1/0/0000", timeout_err, busy, cl_done); end
    tick(); cl_req = 16'h0004; smp();
    n = 0;
    while (cl_gnt == '0 && n < 8) begin tick(); smp(); n++; end
    vectors++; if (cl_gnt !== 16'h0004) begin miscompares++; $display("FAIL t4_next_gnt got=%h exp=0004", cl_gnt); end
    tick(); cl_req = '0; tick(); mc_done = 1'b1; smp();
    vectors++; if (cl_done !== 16'h0004) begin miscompares++; $display("FAIL t4_next_done got=%h exp=0004", cl_done); end
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL t4_sticky got=%0b exp=1", timeout_err); end
    tick(); mc_done = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    tick(); cl_req = 16'h8001; smp();
    n = 0;
    while (cl_gnt == '0 && n < 8) begin tick(); smp(); n++; end
    vectors++; if (cl_gnt !== 16'h8000) begin miscompares++; $display("FAIL t5_gnt15 got=%h exp=8000", cl_gnt); end
    tick(); cl_req = 16'h0001; tick(); mc_done = 1'b1; tick(); mc_done = 1'b0; smp();
    n = 0;
    while (cl_gnt == '0 && n < 8) begin tick(); smp(); n++; end
    vectors++; if (cl_gnt !== 16'h0001) begin miscompares++; $display("FAIL t5_gnt0 got=%h exp=0001", cl_gnt); end
    vectors++; if (client_priority !== 5'd0) begin miscompares++; $display("FAIL t5_prio got=%0d exp=0", client_priority); end
    tick(); cl_req = '0; tick(); mc_done = 1'b1; tick(); mc_done = 1'b0;
  endtask

  task automatic test_reset_busy();
    int n;
    tick(); cl_req = 16'h0010; smp();
    n = 0;
    while (cl_gnt == '0 && n < 8) begin tick(); smp(); n++; end
    vectors++; if (cl_gnt !== 16'h0010) begin miscompares++; $display("FAIL t6_gnt4 got=%h exp=0010", cl_gnt); end
    tick(); cl_req = 16'h0080;
    tick(); rst = 1'b1; mc_done = 1'b1; #1;
    vectors++; if ({busy, mc_valid, timeout_err} !== 3'b000) begin miscompares++; $display("FAIL t6_rst_flags got=%b exp=000", {busy, mc_valid, timeout_err}); end
    vectors++; if (cl_done !== '0) begin miscompares++; $display("FAIL t6_rst_done got=%h exp=0000", cl_done); end
    vectors++; if ({client_priority, read_addr_ddr, write_addr_ddr} !== '0) begin miscompares++; $display("FAIL t6_rst_regs got=%0d/%h/%h exp=0/0/0", client_priority, read_addr_ddr, write_addr_ddr); end
    tick(); rst = 1'b0; mc_done = 1'b0; smp();
    n = 0;
    while (cl_gnt == '0 && n < 8) begin tick(); smp(); n++; end
    vectors++; if (cl_gnt !== 16'h0080) begin miscompares++; $display("FAIL t6_gnt7 got=%h exp=0080", cl_gnt); end
    vectors++; if (client_priority !== 5'd7) begin miscompares++; $display("FAIL t6_prio got=%0d exp=7", client_priority); end
    vectors++; if ({read_addr_ddr, write_addr_ddr} !== {rd_of(7), wr_of(7)}) begin miscompares++; $display("FAIL t6_addrs got=%h/%h exp=%h/%h", read_addr_ddr, write_addr_ddr, rd_of(7), wr_of(7)); end
    tick(); cl_req = '0; tick(); mc_done = 1'b1; tick(); mc_done = 1'b0;
  endtask

  task automatic test_done_at_expiry();
    int n;
    tick(); cl_req = 16'h0002; smp();
    n = 0;
    while (cl_gnt == '0 && n < 8) begin tick(); smp(); n++; end
    vectors++; if (cl_gnt !== 16'h0002) begin miscompares++; $display("FAIL tx_gnt got=%h exp=0002", cl_gnt); end
    for (int c = 1; c <= TO; c++) begin
      tick(); if (c == 1) cl_req = '0;
    end
    tick(); mc_done = 1'b1; smp();
    vectors++; if (cl_done !== 16'h0002) begin miscompares++; $display("FAIL tx_done got=%h exp=0002", cl_done); end
    tick(); mc_done = 1'b0; smp();
    vectors++; if ({timeout_err, busy} !== 2'b00) begin miscompares++; $display("FAIL tx_no_err got=%b exp=00", {timeout_err, busy}); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      cl_rd_addr[i] = rd_of(i);
      cl_wr_addr[i] = wr_of(i);
    end
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_watchdog();
    test_wrap();
    test_reset_busy();
    test_done_at_expiry();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim_time=%0t limit=200000", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
